// File: rtl/i2c_bus_monitor.sv
// Passive I2C decoder: START/STOP/repeated-START detection, MSB-first byte capture with ACK.
// Optional SCL-low watchdog enabled by defining I2C_TIMEOUT_EN (bus_stuck tied 0 otherwise).
module i2c_bus_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda,
    output logic       start_det,
    output logic       stop_det,
    output logic       rep_start,
    output logic       bus_busy,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_ack,
    output logic       is_addr,
    output logic       frame_err,
    output logic       bus_stuck
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BITS = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    logic       scl_q;
    logic       sda_q;
    logic [1:0] state_reg;
    logic [3:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic       first_flag_reg;

    logic scl_rise;
    logic sda_fall;
    logic sda_rise;
    logic start_ev;
    logic stop_ev;
    logic mid_byte;
    logic timeout_hit;

    assign scl_rise = !scl_q && scl;
    assign sda_fall = sda_q && !sda;
    assign sda_rise = !sda_q && sda;

    // SCL must be stable high across the SDA edge; simultaneous changes are not bus conditions.
    assign start_ev = scl_q && scl && sda_fall;
    assign stop_ev  = scl_q && scl && sda_rise;

    assign mid_byte = ((state_reg == ST_BITS) && (bit_cnt_reg != 4'd0)) || (state_reg == ST_ACK);

`ifdef I2C_TIMEOUT_EN
    logic [15:0] low_cnt_reg;
    logic [15:0] low_cnt_inc;
    logic        stuck_reg;

    assign low_cnt_inc = (low_cnt_reg == 16'hFFFF) ? low_cnt_reg : (low_cnt_reg + 16'd1);
    assign timeout_hit = bus_busy && !scl && (low_cnt_inc >= TIMEOUT_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            low_cnt_reg <= 16'd0;
            stuck_reg   <= 1'b0;
        end else begin
            if (scl || start_ev || stop_ev) begin
                low_cnt_reg <= 16'd0;
            end else if (bus_busy) begin
                low_cnt_reg <= low_cnt_inc;
            end
            if (scl_rise) begin
                stuck_reg <= 1'b0;
            end else if (timeout_hit) begin
                stuck_reg <= 1'b1;
            end
        end
    end

    assign bus_stuck = stuck_reg;
`else
    // Keeps the timeout parameter referenced when the watchdog is compiled out.
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT_LIM;
    assign timeout_hit    = 1'b0;
    assign bus_stuck      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q          <= 1'b1;
            sda_q          <= 1'b1;
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= 4'd0;
            shift_reg      <= 8'd0;
            first_flag_reg <= 1'b0;
            start_det      <= 1'b0;
            stop_det       <= 1'b0;
            rep_start      <= 1'b0;
            bus_busy       <= 1'b0;
            byte_valid     <= 1'b0;
            byte_data      <= 8'd0;
            byte_ack       <= 1'b0;
            is_addr        <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            scl_q      <= scl;
            sda_q      <= sda;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (start_ev) begin
                start_det      <= 1'b1;
                rep_start      <= bus_busy;
                bus_busy       <= 1'b1;
                first_flag_reg <= 1'b1;
                bit_cnt_reg    <= 4'd0;
                state_reg      <= ST_BITS;
                frame_err      <= mid_byte;
            end else if (stop_ev) begin
                stop_det    <= 1'b1;
                bus_busy    <= 1'b0;
                bit_cnt_reg <= 4'd0;
                state_reg   <= ST_IDLE;
                frame_err   <= mid_byte;
            end else if (timeout_hit) begin
                bus_busy    <= 1'b0;
                bit_cnt_reg <= 4'd0;
                state_reg   <= ST_IDLE;
            end else if (scl_rise) begin
                case (state_reg)
                    ST_BITS: begin
                        shift_reg   <= {shift_reg[6:0], sda};
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            state_reg <= ST_ACK;
                        end
                    end
                    ST_ACK: begin
                        byte_ack       <= sda;
                        byte_data      <= shift_reg;
                        byte_valid     <= 1'b1;
                        is_addr        <= first_flag_reg;
                        first_flag_reg <= 1'b0;
                        bit_cnt_reg    <= 4'd0;
                        state_reg      <= ST_BITS;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Bench for i2c_bus_monitor: bit-queue protocol model checked every cycle, plus literal per-test checks.
module tb_i2c_bus_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda = 1'b1;
    logic       start_det, stop_det, rep_start, bus_busy, byte_valid;
    logic [7:0] byte_data;
    logic       byte_ack, is_addr, frame_err, bus_stuck;

    int errors = 0;
    int checks = 0;

    i2c_bus_monitor #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda),
        .start_det(start_det), .stop_det(stop_det), .rep_start(rep_start),
        .bus_busy(bus_busy), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ack(byte_ack), .is_addr(is_addr), .frame_err(frame_err),
        .bus_stuck(bus_stuck)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Protocol model: SCL-rise samples collected in a queue, every ninth sample closes a byte.
    logic       m_scl_q = 1'b1, m_sda_q = 1'b1, m_busy = 1'b0, m_first = 1'b0;
    bit         m_bits[$];
    int         m_low = 0;
    logic       e_start = 0, e_stop = 0, e_rep = 0, e_valid = 0, e_ack = 0, e_addr = 0;
    logic       e_ferr = 0, e_stuck = 0;
    logic [7:0] e_data = 8'd0;

    always @(posedge clk) begin
        logic is_start, is_stop, rise;
        if (rst) begin
            m_scl_q = 1'b1; m_sda_q = 1'b1; m_busy = 1'b0; m_first = 1'b0;
            m_bits.delete(); m_low = 0;
            e_start = 0; e_stop = 0; e_rep = 0; e_valid = 0; e_ack = 0; e_addr = 0;
            e_ferr = 0; e_stuck = 0; e_data = 8'd0;
        end else begin
            e_start = 0; e_stop = 0; e_valid = 0; e_ferr = 0;
            is_start = m_scl_q && scl && m_sda_q && !sda;
            is_stop  = m_scl_q && scl && !m_sda_q && sda;
            rise     = !m_scl_q && scl;
            if (is_start) begin
                e_start = 1; e_ferr = m_busy && (m_bits.size() != 0);
                e_rep = m_busy; m_busy = 1; m_first = 1; m_bits.delete();
            end else if (is_stop) begin
                e_stop = 1; e_ferr = m_busy && (m_bits.size() != 0);
                m_busy = 0; m_bits.delete();
            end else if (rise && m_busy) begin
                m_bits.push_back(sda);
                if (m_bits.size() == 9) begin
                    for (int i = 0; i < 8; i++) e_data[7-i] = m_bits[i];
                    e_ack = m_bits[8]; e_addr = m_first; e_valid = 1;
                    m_first = 0; m_bits.delete();
                end
            end
`ifdef I2C_TIMEOUT_EN
            if (scl) begin
                m_low = 0;
            end else if (m_busy) begin
                if (m_low < 65535) m_low++;
                if (m_low >= 100) begin
                    e_stuck = 1; m_busy = 0; m_bits.delete();
                end
            end
            if (rise) e_stuck = 0;
`endif
            m_scl_q = scl; m_sda_q = sda;
        end
    end

    // Per-cycle compare plus event logs used by the literal checks.
    int         n_start = 0, n_stop = 0, n_ferr = 0;
    logic [9:0] vlog[$];
    logic       rlog[$];

    always @(negedge clk) begin
        chk("start_det", start_det, e_start);
        chk("stop_det", stop_det, e_stop);
        chk("rep_start", rep_start, e_rep);
        chk("bus_busy", bus_busy, m_busy);
        chk("byte_valid", byte_valid, e_valid);
        chk("byte_data", byte_data, e_data);
        chk("byte_ack", byte_ack, e_ack);
        chk("is_addr", is_addr, e_addr);
        chk("frame_err", frame_err, e_ferr);
        chk("bus_stuck", bus_stuck, e_stuck);
        if (start_det === 1'b1) begin n_start++; rlog.push_back(rep_start); end
        if (stop_det === 1'b1) n_stop++;
        if (frame_err === 1'b1) n_ferr++;
        if (byte_valid === 1'b1) vlog.push_back({byte_ack, is_addr, byte_data});
    end

    int s_start, s_stop, s_ferr;

    task automatic snap();
        @(posedge clk); #1;
        vlog.delete(); rlog.delete();
        s_start = n_start; s_stop = n_stop; s_ferr = n_ferr;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic s, input logic d);
        @(negedge clk); scl = s; sda = d; @(negedge clk);
    endtask

    task automatic i2c_start();
        set_bus(1'b0, 1'b1); set_bus(1'b1, 1'b1); set_bus(1'b1, 1'b0); set_bus(1'b0, 1'b0);
    endtask

    task automatic i2c_bit(input logic b);
        set_bus(1'b0, b); set_bus(1'b1, b); set_bus(1'b0, b);
    endtask

    task automatic i2c_byte(input logic [7:0] v, input logic ack);
        for (int i = 7; i >= 0; i--) i2c_bit(v[i]);
        i2c_bit(ack);
    endtask

    task automatic i2c_stop();
        set_bus(1'b0, 1'b0); set_bus(1'b1, 1'b0); set_bus(1'b1, 1'b1);
    endtask

    task automatic chk_byte(input string tag, input int idx, input logic [7:0] d,
                            input logic a, input logic ad);
        if (idx < vlog.size()) begin
            chk({tag, "_data"}, vlog[idx][7:0], d);
            chk({tag, "_ack"}, {7'd0, vlog[idx][9]}, {7'd0, a});
            chk({tag, "_addr"}, {7'd0, vlog[idx][8]}, {7'd0, ad});
        end else begin
            chk({tag, "_missing"}, 8'(vlog.size()), 8'(idx + 1));
        end
    endtask

    initial begin
        logic [7:0] v;
        repeat (3) @(negedge clk);
        chk("reset_busy", {7'd0, bus_busy}, 8'd0);
        chk("reset_data", byte_data, 8'd0);
        @(negedge clk); rst = 1'b0;

        // 1: single address byte with ACK
        snap();
        i2c_start(); i2c_byte(8'hA0, 1'b0); i2c_stop(); settle();
        chk("t1_starts", 8'(n_start - s_start), 8'd1);
        chk("t1_stops", 8'(n_stop - s_stop), 8'd1);
        chk("t1_nbytes", 8'(vlog.size()), 8'd1);
        chk_byte("t1_b0", 0, 8'hA0, 1'b0, 1'b1);
        chk("t1_busy", {7'd0, bus_busy}, 8'd0);
        $display("t1 start/A0/stop: bytes=%0d", vlog.size());

        // 2: address then data byte with NACK
        snap();
        i2c_start(); i2c_byte(8'h50, 1'b0); i2c_byte(8'h3C, 1'b1); i2c_stop(); settle();
        chk("t2_nbytes", 8'(vlog.size()), 8'd2);
        chk_byte("t2_b0", 0, 8'h50, 1'b0, 1'b1);
        chk_byte("t2_b1", 1, 8'h3C, 1'b1, 1'b0);
        $display("t2 start/50/3C/stop: bytes=%0d", vlog.size());

        // 3: repeated START
        snap();
        i2c_start(); i2c_byte(8'hA0, 1'b0); i2c_start(); i2c_byte(8'hA1, 1'b0); i2c_stop(); settle();
        chk("t3_starts", 8'(n_start - s_start), 8'd2);
        chk("t3_rep_first", (rlog.size() > 0) ? {7'd0, rlog[0]} : 8'hEE, 8'd0);
        chk("t3_rep_second", (rlog.size() > 1) ? {7'd0, rlog[1]} : 8'hEE, 8'd1);
        chk_byte("t3_b0", 0, 8'hA0, 1'b0, 1'b1);
        chk_byte("t3_b1", 1, 8'hA1, 1'b0, 1'b1);
        $display("t3 repeated start: starts=%0d bytes=%0d", n_start - s_start, vlog.size());

        // 4: STOP after a partial byte
        snap();
        v = 8'hF0;
        i2c_start();
        for (int i = 7; i >= 4; i--) i2c_bit(v[i]);
        i2c_stop(); settle();
        chk("t4_nbytes", 8'(vlog.size()), 8'd0);
        chk("t4_ferr", 8'(n_ferr - s_ferr), 8'd1);
        chk("t4_stops", 8'(n_stop - s_stop), 8'd1);
        chk("t4_busy", {7'd0, bus_busy}, 8'd0);
        $display("t4 partial byte stop: frame_err=%0d", n_ferr - s_ferr);

        // 5: simultaneous SCL/SDA changes and SCL pulses while idle
        snap();
        set_bus(1'b1, 1'b1); set_bus(1'b0, 1'b0); set_bus(1'b1, 1'b1);
        set_bus(1'b0, 1'b0); set_bus(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin set_bus(1'b0, 1'b1); set_bus(1'b1, 1'b1); end
        settle();
        chk("t5_starts", 8'(n_start - s_start), 8'd0);
        chk("t5_stops", 8'(n_stop - s_stop), 8'd0);
        chk("t5_nbytes", 8'(vlog.size()), 8'd0);
        $display("t5 idle toggles: events=%0d", (n_start - s_start) + (n_stop - s_stop));

        // 5b: SDA changing together with each SCL edge mid-transfer
        snap();
        v = 8'h5A;
        i2c_start();
        for (int i = 7; i >= 0; i--) begin set_bus(1'b0, !v[i]); set_bus(1'b1, v[i]); end
        set_bus(1'b0, 1'b1); set_bus(1'b1, 1'b0); set_bus(1'b0, 1'b1);
        i2c_stop(); settle();
        chk("t5b_starts", 8'(n_start - s_start), 8'd1);
        chk_byte("t5b_b0", 0, 8'h5A, 1'b0, 1'b1);
        $display("t5b same-cycle edges: bytes=%0d", vlog.size());

        // 7: reset mid-transfer, then clocking without START, then STOP in IDLE
        snap();
        i2c_start(); i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1);
        @(negedge clk); rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
        i2c_byte(8'hC3, 1'b0);
        snap();
        i2c_stop(); settle();
        chk("t7_nbytes", 8'(vlog.size()), 8'd0);
        chk("t7_stops", 8'(n_stop - s_stop), 8'd1);
        chk("t7_ferr", 8'(n_ferr - s_ferr), 8'd0);
        chk("t7_busy", {7'd0, bus_busy}, 8'd0);
        $display("t7 reset mid-transfer: stops=%0d bytes=%0d", n_stop - s_stop, vlog.size());

`ifdef I2C_TIMEOUT_EN
        // 6: SCL held low past the timeout
        snap();
        i2c_start();
        repeat (110) @(negedge clk);
        @(posedge clk); #1;
        chk("t6_stuck", {7'd0, bus_stuck}, 8'd1);
        chk("t6_busy", {7'd0, bus_busy}, 8'd0);
        set_bus(1'b1, 1'b0);
        @(posedge clk); #1;
        chk("t6_released", {7'd0, bus_stuck}, 8'd0);
        set_bus(1'b1, 1'b1); settle();
        $display("t6 timeout: bus_stuck cleared=%0d", !bus_stuck);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
